mpc_mux_sel_seq: RTL and testbench

MPC_MUX_SEL_SEQ -- requirements
Module: mpc_mux_sel_seq

---
 rtl/mpc_mux_sel_seq_if.sv | 30 +++
 rtl/mpc_mux_sel_seq.sv | 157 +++++++++++++++
 tb/tb_mpc_mux_sel_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mpc_mux_sel_seq_if.sv
// Bundle of the bank-write, sweep-control and mux-select signals of mpc_mux_sel_seq.
// master drives writes/start/sel_rdy; slave is the sequencer side.
interface mpc_mux_sel_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr_en;
  logic [1:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic [1:0]            din4;
  logic                  sel_vld;
  logic                  sel_rdy;
  logic                  busy;
  logic                  done;
  logic                  wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, sel_rdy,
    input  din0, din1, din2, din3, din4, sel_vld, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, sel_rdy,
    output din0, din1, din2, din3, din4, sel_vld, busy, done, wr_err
  );
endinterface

// File: rtl/mpc_mux_sel_seq.sv
// Four-entry bank feeding a 4:1 mux plus a select-index sweeper (IDLE/RUN/DONE).
// Optional macro MPC_SEL_SEQ_BANK_LOCK_EN: drop bank writes while busy and pulse wr_err.

module mpc_sel_bank_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = ld_data;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) data_q <= '0;
    else           data_q <= data_d;
  end

  assign q = data_q;
endmodule

module mpc_mux_sel_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int LAST_IDX   = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] din1,
  output logic [DATA_WIDTH-1:0] din2,
  output logic [DATA_WIDTH-1:0] din3,
  output logic [1:0]            din4,
  output logic                  sel_vld,
  input  logic                  sel_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);
  localparam int         NUM_ENTRIES = 4;
  localparam logic [1:0] LAST        = LAST_IDX[1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       busy_int;
  logic       wr_ok;

  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] bank;
  logic [NUM_ENTRIES-1:0]                 ld;

  assign busy_int = (state_q != IDLE);

`ifdef MPC_SEL_SEQ_BANK_LOCK_EN
  logic wr_err_q, wr_err_d;

  // Bank is frozen for the whole sweep so the consumer sees a consistent snapshot.
  always_comb begin
    wr_ok    = wr_en & ~busy_int;
    wr_err_d = wr_en & busy_int;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) wr_err_q <= 1'b0;
    else           wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;
`else
  assign wr_ok  = wr_en;
  assign wr_err = 1'b0;
`endif

  always_comb begin
    ld = '0;
    if (wr_ok) ld[wr_addr] = 1'b1;
  end

  // Registered entries: a same-cycle write only shows on din* one cycle later.
  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
    mpc_sel_bank_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .ld      (ld[e]),
      .ld_data (wr_data),
      .q       (bank[e])
    );
  end

  assign din0 = bank[0];
  assign din1 = bank[1];
  assign din2 = bank[2];
  assign din3 = bank[3];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_vld = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 2'd0;
        end
      end
      RUN: begin
        sel_vld = 1'b1;
        if (sel_rdy) begin
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        idx_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx is forced to 0 whenever the FSM leaves RUN, so it can drive din4 directly.
  assign din4 = idx_q;
  assign busy = busy_int;
endmodule

// File: tb/tb_mpc_mux_sel_seq.sv
// Randomised + directed bench: two sequencers (LAST_IDX 3 and 1) share stimulus and are
// checked against a sweep-level reference model through an expected-index scoreboard.
module tb_mpc_mux_sel_seq;
  localparam int DW = 32;
`ifdef MPC_SEL_SEQ_BANK_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          sel_rdy = 1'b0;

  always #5 ap_clk = ~ap_clk;

  mpc_mux_sel_seq_if #(.DATA_WIDTH(DW)) if_a ();
  mpc_mux_sel_seq_if #(.DATA_WIDTH(DW)) if_b ();

  assign if_a.wr_en   = wr_en;
  assign if_a.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;
  assign if_a.start   = start;
  assign if_a.sel_rdy = sel_rdy;
  assign if_b.wr_en   = wr_en;
  assign if_b.wr_addr = wr_addr;
  assign if_b.wr_data = wr_data;
  assign if_b.start   = start;
  assign if_b.sel_rdy = sel_rdy;

  mpc_mux_sel_seq #(.DATA_WIDTH(DW), .LAST_IDX(3)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .wr_en(if_a.wr_en), .wr_addr(if_a.wr_addr), .wr_data(if_a.wr_data), .start(if_a.start),
    .din0(if_a.din0), .din1(if_a.din1), .din2(if_a.din2), .din3(if_a.din3), .din4(if_a.din4),
    .sel_vld(if_a.sel_vld), .sel_rdy(if_a.sel_rdy), .busy(if_a.busy), .done(if_a.done),
    .wr_err(if_a.wr_err)
  );

  mpc_mux_sel_seq #(.DATA_WIDTH(DW), .LAST_IDX(1)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .wr_en(if_b.wr_en), .wr_addr(if_b.wr_addr), .wr_data(if_b.wr_data), .start(if_b.start),
    .din0(if_b.din0), .din1(if_b.din1), .din2(if_b.din2), .din3(if_b.din3), .din4(if_b.din4),
    .sel_vld(if_b.sel_vld), .sel_rdy(if_b.sel_rdy), .busy(if_b.busy), .done(if_b.done),
    .wr_err(if_b.wr_err)
  );

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;

  // Reference model: bank contents, queue of indices still owed by the current sweep,
  // and one-cycle flags for the done and wr_err pulses.
  logic [DW-1:0] mbank [2][4];
  int unsigned   exp_q [2][$];
  bit            done_now [2];
  bit            err_now [2];

  function automatic int last_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ap_clk) begin
    logic [DW-1:0] o_din [4];
    logic [1:0]    o_d4;
    logic          o_vld, o_busy, o_done, o_err;
    bit            busy_e;
    string         tg;
    chk("timeout", tmo_cnt, tmo_seen);
    tmo_seen = tmo_cnt;
    for (int k = 0; k < 2; k++) begin
      tg = (k == 0) ? "L3" : "L1";
      if (k == 0) begin
        o_din[0] = if_a.din0; o_din[1] = if_a.din1; o_din[2] = if_a.din2; o_din[3] = if_a.din3;
        o_d4 = if_a.din4; o_vld = if_a.sel_vld; o_busy = if_a.busy;
        o_done = if_a.done; o_err = if_a.wr_err;
      end else begin
        o_din[0] = if_b.din0; o_din[1] = if_b.din1; o_din[2] = if_b.din2; o_din[3] = if_b.din3;
        o_d4 = if_b.din4; o_vld = if_b.sel_vld; o_busy = if_b.busy;
        o_done = if_b.done; o_err = if_b.wr_err;
      end
      if (!ap_rst_n) begin
        for (int i = 0; i < 4; i++) chk({tg, ".rst_din"}, o_din[i], 0);
        chk({tg, ".rst_din4"}, o_d4, 0);
        chk({tg, ".rst_sel_vld"}, o_vld, 0);
        chk({tg, ".rst_busy"}, o_busy, 0);
        chk({tg, ".rst_done"}, o_done, 0);
        chk({tg, ".rst_wr_err"}, o_err, 0);
        for (int i = 0; i < 4; i++) mbank[k][i] = '0;
        exp_q[k].delete();
        done_now[k] = 1'b0;
        err_now[k]  = 1'b0;
      end else begin
        busy_e = (exp_q[k].size() != 0) || done_now[k];
        for (int i = 0; i < 4; i++) chk({tg, ".din"}, o_din[i], mbank[k][i]);
        chk({tg, ".sel_vld"}, o_vld, exp_q[k].size() != 0);
        if (exp_q[k].size() != 0) chk({tg, ".din4"}, o_d4, exp_q[k][0]);
        chk({tg, ".done"}, o_done, done_now[k]);
        chk({tg, ".busy"}, o_busy, busy_e);
        chk({tg, ".wr_err"}, o_err, err_now[k]);
        // Predict the effect of the coming rising edge from the inputs now on the pins.
        err_now[k]  = LOCK && wr_en && busy_e;
        done_now[k] = 1'b0;
        if (exp_q[k].size() != 0 && sel_rdy) begin
          chk({tg, ".mux_out"}, o_din[o_d4], mbank[k][exp_q[k][0]]);
          void'(exp_q[k].pop_front());
          if (exp_q[k].size() == 0) done_now[k] = 1'b1;
        end
        if (!busy_e && start)
          for (int i = 0; i <= last_of(k); i++) exp_q[k].push_back(i);
        if (wr_en && !(LOCK && busy_e)) mbank[k][wr_addr] = wr_data;
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((if_a.busy || if_b.busy) && n < bound) begin step(); n++; end
    if (if_a.busy || if_b.busy) tmo_cnt++;
  endtask

  task automatic wait_a_idx(input logic [1:0] v, input int bound);
    int n = 0;
    while (!(if_a.sel_vld && if_a.din4 == v) && n < bound) begin step(); n++; end
    if (!(if_a.sel_vld && if_a.din4 == v)) tmo_cnt++;
  endtask

  initial begin
    repeat (3) step();
    ap_rst_n = 1'b1;
    step();
    // Basic sweep with free-flowing consumer
    write(2'd0, 32'h11); write(2'd1, 32'h22); write(2'd2, 32'h33); write(2'd3, 32'h44);
    sel_rdy = 1'b1;
    pulse_start();
    wait_idle(20);
    step();
    // Consumer stalls three cycles at idx 1
    pulse_start();
    wait_a_idx(2'd1, 10);
    sel_rdy = 1'b0;
    repeat (3) step();
    sel_rdy = 1'b1;
    wait_idle(20);
    step();
    // Reset pulse mid-sweep at idx 2
    pulse_start();
    wait_a_idx(2'd2, 10);
    ap_rst_n = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
    step();
    // Write during RUN
    write(2'd0, 32'h11); write(2'd1, 32'h22); write(2'd2, 32'h33); write(2'd3, 32'h44);
    sel_rdy = 1'b0;
    pulse_start();
    step();
    write(2'd3, 32'hDEAD);
    step();
    sel_rdy = 1'b1;
    wait_idle(20);
    step();
    // start held during RUN/DONE
    pulse_start();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_idle(20);
    step();
    // Randomised traffic
    repeat (400) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 2'($urandom % 4);
      wr_data = $urandom;
      start   = ($urandom % 8) == 0;
      sel_rdy = ($urandom % 4) != 0;
      if (($urandom % 150) == 0) ap_rst_n = 1'b0;
      step();
      ap_rst_n = 1'b1;
    end
    wr_en = 1'b0; start = 1'b0; sel_rdy = 1'b1;
    wait_idle(30);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
